// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one burst memory port between two cache controllers. A requester
//   raises a block request (address + direction), the arbiter grants one of
//   them round-robin, issues the command downstream, then routes exactly
//   BEATS data beats between the owner and memory before re-arbitrating.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/rw/addr/ready    per-requester block command channel
//   wvalid/wdata/wready        per-requester write beat channel
//   rvalid/rready, rdata       per-requester read beat channel (rdata broadcast)
//   m_cmd_*                    memory command channel
//   m_w*                       memory write beat channel (m_wlast generated here)
//   m_r*                       memory read beat channel (m_rlast checked here)
//   err_rlast                  sticky flag: m_rlast disagreed with the beat count
module mem_port_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int BEATS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_rw,
    input  logic [2*AW-1:0] req_addr,
    output logic [1:0]      req_ready,
    input  logic [1:0]      wvalid,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      wready,
    output logic [1:0]      rvalid,
    input  logic [1:0]      rready,
    output logic [DW-1:0]   rdata,
    output logic            m_cmd_valid,
    input  logic            m_cmd_ready,
    output logic            m_cmd_rw,
    output logic [AW-1:0]   m_cmd_addr,
    output logic            m_wvalid,
    input  logic            m_wready,
    output logic [DW-1:0]   m_wdata,
    output logic            m_wlast,
    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_rlast,
    output logic            err_rlast
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t        state;
    logic          owner;
    logic          rr_ptr;
    logic          cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [CW-1:0] beat_cnt;

    logic win;
    logic is_last;
    logic w_hs;
    logic r_hs;

    // A lone requester wins outright; a tie goes to the favoured one.
    always_comb begin
        case (req_valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = rr_ptr;
        endcase
    end

    assign is_last = (beat_cnt == LAST_BEAT);
    assign w_hs    = (state == WDATA) && m_wvalid && m_wready;
    assign r_hs    = (state == RDATA) && m_rvalid && m_rready;

    assign m_cmd_valid = (state == CMD);
    assign m_cmd_rw    = cmd_rw;
    assign m_cmd_addr  = cmd_addr;

    // Data channels are only connected to the owner during its burst;
    // everything else is held at zero.
    always_comb begin
        req_ready = 2'b00;
        wready    = 2'b00;
        rvalid    = 2'b00;
        rdata     = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wlast   = 1'b0;
        m_rready  = 1'b0;
        case (state)
            CMD: begin
                req_ready[owner] = m_cmd_ready;
            end
            WDATA: begin
                m_wvalid      = wvalid[owner];
                m_wdata       = owner ? wdata[2*DW-1:DW] : wdata[DW-1:0];
                wready[owner] = m_wready;
                m_wlast       = wvalid[owner] && is_last;
            end
            RDATA: begin
                rvalid[owner] = m_rvalid;
                m_rready      = rready[owner];
                rdata         = m_rdata;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr_ptr    <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_addr  <= '0;
            beat_cnt  <= '0;
            err_rlast <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner    <= win;
                        cmd_rw   <= req_rw[win];
                        cmd_addr <= win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                        state    <= CMD;
                    end
                end
                // Requester inputs are not looked at again here: the latched
                // command is issued even if the requester drops its valid.
                CMD: begin
                    if (m_cmd_ready) begin
                        beat_cnt <= '0;
                        state    <= cmd_rw ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        if (is_last) begin
                            state  <= IDLE;
                            rr_ptr <= ~owner;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                // The burst length is set by the count; m_rlast is only checked.
                RDATA: begin
                    if (r_hs) begin
                        if (m_rlast != is_last)
                            err_rlast <= 1'b1;
                        if (is_last) begin
                            state  <= IDLE;
                            rr_ptr <= ~owner;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
